// File: rtl/ahblite_led_pwm.sv
// AHB-Lite slave driving NUM_CH PWM LEDs with period-aligned duty shadows.
// Define LED_PWM_BLINK_EN to add the per-channel BLINK bit (DUTY_i[16]) and blink phase logic.

module ahblite_led_pwm #(
  parameter int NUM_CH = 4,
  parameter int PWM_W  = 8,
  parameter int PRE_W  = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [3:0]        HPROT,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic [NUM_CH-1:0] led
);

  localparam logic [5:0] ADDR_CTRL  = 6'd0;
  localparam logic [5:0] ADDR_PRESC = 6'd1;
  localparam logic [5:0] ADDR_STAT  = 6'd2;
  localparam logic [5:0] ADDR_DUTY0 = 6'd4;

  logic             dp_valid;
  logic             dp_write;
  logic [5:0]       dp_addr;
  logic             wr_en;
  logic             presc_wr;
  logic             en;
  logic [PRE_W-1:0] presc;
  logic [PRE_W-1:0] pre_cnt;
  logic [PWM_W-1:0] pwm_cnt;
  logic             tick;
  logic             wrap;
  logic [PWM_W-1:0] duty   [NUM_CH];
  logic [PWM_W-1:0] shadow [NUM_CH];
  logic [NUM_CH-1:0] gate;
  logic [NUM_CH-1:0] led_next;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign HREADYOUT   = 1'b1;
  assign HRESP       = 1'b0;
  assign unused_bits = ^{HSIZE, HPROT, HADDR[31:8], HADDR[1:0], HTRANS[0], HWDATA};

  // Address phase capture; the data phase only advances while the bus is ready.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
    end else if (HREADY) begin
      dp_valid <= HSEL & HTRANS[1];
      dp_write <= HWRITE;
      dp_addr  <= HADDR[7:2];
    end
  end

  assign wr_en    = dp_valid & dp_write & HREADY;
  assign presc_wr = wr_en & (dp_addr == ADDR_PRESC);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en    <= 1'b0;
      presc <= '0;
    end else if (wr_en) begin
      case (dp_addr)
        ADDR_CTRL:  en    <= HWDATA[0];
        ADDR_PRESC: presc <= HWDATA[PRE_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NUM_CH; i++) duty[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (wr_en && dp_addr == ADDR_DUTY0 + 6'(i)) duty[i] <= HWDATA[PWM_W-1:0];
    end
  end

  assign tick = en & (pre_cnt == presc);
  assign wrap = tick & (pwm_cnt == '1);

  // A PRESC write restarts the prescale interval so the new value takes effect cleanly.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (!en) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      if (presc_wr || tick) pre_cnt <= '0;
      else                  pre_cnt <= pre_cnt + PRE_W'(1);
      if (tick)             pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
  end

  // Shadows follow DUTY while disabled and otherwise reload only at the period boundary.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else if (!en || wrap) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= duty[i];
    end
  end

`ifdef LED_PWM_BLINK_EN
  logic [NUM_CH-1:0] blink;
  logic [3:0]        blink_cnt;
  logic              phase;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      blink <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (wr_en && dp_addr == ADDR_DUTY0 + 6'(i)) blink[i] <= HWDATA[16];
    end
  end

  // Phase flips after every 16 completed PWM periods.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (!en) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (wrap) begin
      blink_cnt <= blink_cnt + 4'd1;
      if (blink_cnt == 4'hF) phase <= ~phase;
    end
  end

  assign gate = blink & {NUM_CH{phase}};
`else
  assign gate = '0;
`endif

  always_comb begin
    led_next = '0;
    for (int i = 0; i < NUM_CH; i++)
      led_next[i] = en & (pwm_cnt < shadow[i]) & ~gate[i];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) led <= '0;
    else          led <= led_next;
  end

  always_comb begin
    rdata = '0;
    if (dp_valid && !dp_write) begin
      case (dp_addr)
        ADDR_CTRL:  rdata[0]          = en;
        ADDR_PRESC: rdata[PRE_W-1:0]  = presc;
        ADDR_STAT:  rdata[PWM_W-1:0]  = pwm_cnt;
        default: ;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
        if (dp_addr == ADDR_DUTY0 + 6'(i)) begin
          rdata[PWM_W-1:0] = duty[i];
`ifdef LED_PWM_BLINK_EN
          rdata[16] = blink[i];
`endif
        end
      end
    end
  end

  assign HRDATA = rdata;

endmodule
